// File: rtl/scan_hold_mux.sv
// scan_hold_mux: fully registered N-channel word selector with direct, hold/load and timed scan modes.
// Scan mode and its counters exist only when SCAN_HOLD_MUX_SCAN_EN is defined; otherwise mode 10 acts as hold.

module scan_hold_mux_chk #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input logic            clock,
  input logic            reset_n,
  input logic [1:0]      mode,
  input logic            load,
  input logic [SELW-1:0] out_ch,
  input logic            out_valid
);
  localparam logic [SELW:0] NCH_W = NCH[SELW:0];

  a_ch_in_range: assert property (@(posedge clock) disable iff (!reset_n)
    out_valid |-> ({1'b0, out_ch} < NCH_W));

  a_hold_idle: assert property (@(posedge clock) disable iff (!reset_n)
    (mode == 2'b01 && !load) |=> !out_valid);
endmodule

module scan_hold_mux #(
  parameter int  WIDTH = 8,
  parameter int  NCH   = 4,
  parameter int  DWELL = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NCH*WIDTH-1:0] in_bus,
  input  logic [1:0]           mode,
  input  logic [SELW-1:0]      sel,
  input  logic                 load,
  output logic [WIDTH-1:0]     out,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid
);
  localparam logic [SELW:0] NCH_W       = NCH[SELW:0];
  localparam logic [1:0]    MODE_DIRECT = 2'b00;

  if (WIDTH < 1 || NCH < 2 || DWELL < 1) begin : g_bad_params
    $error("scan_hold_mux: illegal parameter set");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             wr_s;
  logic [SELW-1:0]  wr_ch_s;
  logic [WIDTH-1:0] word_s;
  logic             sel_ok_s;

  // Only matters when NCH is not a power of two: such indices never write.
  assign sel_ok_s = ({1'b0, sel} < NCH_W);

`ifdef SCAN_HOLD_MUX_SCAN_EN
  localparam int              DCW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0]  DWELL_LAST = DCW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_LAST    = SELW'(NCH - 1);
  localparam logic [1:0]      MODE_SCAN  = 2'b10;

  logic [SELW-1:0] scan_ch_q, scan_ch_d, scan_cur_ch_s;
  logic [DCW-1:0]  dwell_cnt_q, dwell_cnt_d, scan_cur_cnt_s;
  logic [1:0]      prev_mode_q;
  logic            scan_entry_s;

  // A fresh entry into scan restarts at channel 0, discarding counters frozen on the last exit.
  always_comb begin
    scan_entry_s = (mode == MODE_SCAN) && (prev_mode_q != MODE_SCAN);
    if (scan_entry_s) begin
      scan_cur_ch_s  = '0;
      scan_cur_cnt_s = '0;
    end else begin
      scan_cur_ch_s  = scan_ch_q;
      scan_cur_cnt_s = dwell_cnt_q;
    end
  end

  // Scan position and previous-mode registers; reset leaves the block as if it had been in hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_ch_q   <= '0;
      dwell_cnt_q <= '0;
      prev_mode_q <= 2'b01;
    end else begin
      scan_ch_q   <= scan_ch_d;
      dwell_cnt_q <= dwell_cnt_d;
      prev_mode_q <= mode;
    end
  end
`endif

  // Write decision: which channel (if any) is captured this cycle, plus scan counter advance.
  always_comb begin
    wr_s    = 1'b0;
    wr_ch_s = sel;
`ifdef SCAN_HOLD_MUX_SCAN_EN
    scan_ch_d   = scan_ch_q;
    dwell_cnt_d = dwell_cnt_q;
`endif
    case (mode)
      MODE_DIRECT: begin
        wr_s = sel_ok_s;
      end
`ifdef SCAN_HOLD_MUX_SCAN_EN
      MODE_SCAN: begin
        wr_s    = 1'b1;
        wr_ch_s = scan_cur_ch_s;
        if (scan_cur_cnt_s == DWELL_LAST) begin
          dwell_cnt_d = '0;
          if (scan_cur_ch_s == CH_LAST) begin
            scan_ch_d = '0;
          end else begin
            scan_ch_d = scan_cur_ch_s + 1'b1;
          end
        end else begin
          dwell_cnt_d = scan_cur_cnt_s + 1'b1;
          scan_ch_d   = scan_cur_ch_s;
        end
      end
`endif
      default: begin
        if (load) begin
          wr_s = sel_ok_s;
        end else begin
          wr_s = 1'b0;
        end
      end
    endcase
  end

  // AND-OR word mux keeps the channel index from ever reaching past the bus.
  always_comb begin
    word_s = '0;
    for (int k = 0; k < NCH; k++) begin
      word_s = word_s | (in_bus[k*WIDTH +: WIDTH] & {WIDTH{wr_ch_s == SELW'(k)}});
    end
  end

  // Output next-state: capture on write, otherwise hold the word and drop valid.
  always_comb begin
    if (wr_s) begin
      out_d       = word_s;
      out_ch_d    = wr_ch_s;
      out_valid_d = 1'b1;
    end else begin
      out_d       = out_q;
      out_ch_d    = out_ch_q;
      out_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

  scan_hold_mux_chk #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_chk (
    .clock     (clock),
    .reset_n   (reset_n),
    .mode      (mode),
    .load      (load),
    .out_ch    (out_ch_q),
    .out_valid (out_valid_q)
  );
endmodule

// File: tb/tb_scan_hold_mux.sv
// Self-checking bench for scan_hold_mux: a 4-channel/DWELL=3 instance and a 3-channel instance
// for out-of-range selects, checked against a cycle-position reference model.

module tb_scan_hold_mux;
  logic        clock;
  logic        reset_n;
  logic [31:0] bus;
  logic [1:0]  mode, sel;
  logic        load;
  logic [7:0]  out1;
  logic [1:0]  ch1;
  logic        valid1;
  logic [23:0] bus3;
  logic [1:0]  mode3, sel3;
  logic        load3;
  logic [7:0]  out3;
  logic [1:0]  ch3;
  logic        valid3;

  int checks = 0;
  int failures = 0;

  scan_hold_mux #(.WIDTH(8), .NCH(4), .DWELL(3)) u_dut (
    .clock(clock), .reset_n(reset_n), .in_bus(bus), .mode(mode), .sel(sel), .load(load),
    .out(out1), .out_ch(ch1), .out_valid(valid1)
  );

  scan_hold_mux #(.WIDTH(8), .NCH(3), .DWELL(2)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .in_bus(bus3), .mode(mode3), .sel(sel3), .load(load3),
    .out(out3), .out_ch(ch3), .out_valid(valid3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: scan channel derived from cycles elapsed since scan entry.
  typedef struct {
    logic [7:0] out;
    logic [1:0] ch;
    logic       valid;
    bit         in_scan;
    int         pos;
  } mstate_t;

  mstate_t m1, m3;

  function automatic mstate_t mreset();
    mstate_t r;
    r.out = 8'h00; r.ch = 2'd0; r.valid = 1'b0; r.in_scan = 1'b0; r.pos = 0;
    return r;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input logic [31:0] b, input logic [1:0] md,
                                    input logic [1:0] sl, input logic ld, input int nch, input int dwell);
    mstate_t n = s;
    bit wr = 1'b0;
    int ch = int'(sl);
    bit scan_mode = 1'b0;
`ifdef SCAN_HOLD_MUX_SCAN_EN
    scan_mode = (md == 2'b10);
`endif
    if (scan_mode) begin
      if (!s.in_scan) n.pos = 0;
      ch = (n.pos / dwell) % nch;
      wr = 1'b1;
      n.pos = n.pos + 1;
    end else if (md == 2'b00) begin
      wr = (int'(sl) < nch);
    end else begin
      wr = ld && (int'(sl) < nch);
    end
    n.in_scan = scan_mode;
    if (wr) begin
      n.out = 8'((b >> (ch * 8)) & 32'hFF);
      n.ch = 2'(ch);
      n.valid = 1'b1;
    end else begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model consumes the inputs sampled at the edge, DUT outputs compared on the falling edge.
  task automatic tick();
    @(posedge clock);
    if (reset_n) begin
      m1 = mstep(m1, bus, mode, sel, load, 4, 3);
      m3 = mstep(m3, {8'h00, bus3}, mode3, sel3, load3, 3, 2);
    end
    @(negedge clock);
    check("model.out", out1, m1.out);
    check("model.out_ch", ch1, m1.ch);
    check("model.out_valid", valid1, m1.valid);
    check("model3.out", out3, m3.out);
    check("model3.out_ch", ch3, m3.ch);
    check("model3.out_valid", valid3, m3.valid);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic        load;
    logic [31:0] bus;
    int          reps;
    logic [7:0]  e_out;
    logic [1:0]  e_ch;
    logic        e_valid;
  } vec_t;

  vec_t vt[7];
  int   exp_scan[13];

  initial begin
    logic [7:0] word;
    int run;
    vt[0] = '{2'b00, 2'd2, 1'b0, 32'h44A52211, 1,  8'hA5, 2'd2, 1'b1};
    vt[1] = '{2'b01, 2'd2, 1'b0, 32'h443C2211, 10, 8'hA5, 2'd2, 1'b0};
    vt[2] = '{2'b01, 2'd1, 1'b1, 32'h443C7711, 1,  8'h77, 2'd1, 1'b1};
    vt[3] = '{2'b01, 2'd1, 1'b0, 32'h443C7711, 1,  8'h77, 2'd1, 1'b0};
    vt[4] = '{2'b11, 2'd3, 1'b1, 32'h443C7711, 1,  8'h44, 2'd3, 1'b1};
    vt[5] = '{2'b11, 2'd3, 1'b0, 32'h443C7711, 1,  8'h44, 2'd3, 1'b0};
    vt[6] = '{2'b00, 2'd0, 1'b0, 32'h443C7711, 1,  8'h11, 2'd0, 1'b1};
    exp_scan = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

    reset_n = 1'b0;
    bus = 32'h0; mode = 2'b00; sel = 2'd0; load = 1'b0;
    bus3 = 24'h0; mode3 = 2'b00; sel3 = 2'd0; load3 = 1'b0;
    m1 = mreset();
    m3 = mreset();
    repeat (2) @(negedge clock);
    check("reset.out", out1, 8'h00);
    check("reset.out_ch", ch1, 2'd0);
    check("reset.out_valid", valid1, 1'b0);
    check("reset3.out_valid", valid3, 1'b0);
    reset_n = 1'b1;

    // Directed direct/hold/load vectors.
    for (int i = 0; i < 7; i++) begin
      mode = vt[i].mode; sel = vt[i].sel; load = vt[i].load; bus = vt[i].bus;
      for (int r = 0; r < vt[i].reps; r++) begin
        tick();
        check($sformatf("vec%0d.out", i), out1, vt[i].e_out);
        check($sformatf("vec%0d.out_ch", i), ch1, vt[i].e_ch);
        check($sformatf("vec%0d.out_valid", i), valid1, vt[i].e_valid);
      end
    end

    // Scan from hold with wrap (mode 10 holds when scan is compiled out).
    mode = 2'b01; load = 1'b0;
    tick();
    mode = 2'b10;
    for (int i = 0; i < 13; i++) begin
      bus = $urandom | 32'h01010101;
      tick();
`ifdef SCAN_HOLD_MUX_SCAN_EN
      word = 8'((bus >> (exp_scan[i] * 8)) & 32'hFF);
      check($sformatf("scan%0d.out_ch", i), ch1, 2'(exp_scan[i]));
      check($sformatf("scan%0d.out", i), out1, word);
      check($sformatf("scan%0d.out_valid", i), valid1, 1'b1);
`else
      check($sformatf("hold10_%0d.out", i), out1, 8'h11);
      check($sformatf("hold10_%0d.out_valid", i), valid1, 1'b0);
`endif
    end

    // Advance to channel 2, second dwell cycle, then leave and re-enter scan.
    for (int i = 0; i < 7; i++) begin
      bus = $urandom | 32'h01010101;
      tick();
    end
    mode = 2'b00; sel = 2'd1;
    repeat (2) tick();
    check("direct_mid.out_ch", ch1, 2'd1);
    mode = 2'b10;
    tick();
`ifdef SCAN_HOLD_MUX_SCAN_EN
    check("reentry.out_ch", ch1, 2'd0);
    check("reentry.out_valid", valid1, 1'b1);
`else
    check("reentry.out_ch", ch1, 2'd1);
    check("reentry.out_valid", valid1, 1'b0);
`endif

    // Asynchronous reset between edges while scanning.
    repeat (4) begin
      bus = $urandom | 32'h01010101;
      tick();
    end
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst.out", out1, 8'h00);
    check("async_rst.out_ch", ch1, 2'd0);
    check("async_rst.out_valid", valid1, 1'b0);
    m1 = mreset();
    m3 = mreset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("post_rst.out_ch", ch1, 2'd0);
`ifdef SCAN_HOLD_MUX_SCAN_EN
    check("post_rst.out_valid", valid1, 1'b1);
`else
    check("post_rst.out_valid", valid1, 1'b0);
`endif

    // Out-of-range select on the 3-channel instance.
    bus3 = 24'h332211; mode3 = 2'b00; sel3 = 2'd1;
    tick();
    check("oor.pre.out", out3, 8'h22);
    check("oor.pre.out_valid", valid3, 1'b1);
    sel3 = 2'd3;
    tick();
    check("oor.direct.out", out3, 8'h22);
    check("oor.direct.out_ch", ch3, 2'd1);
    check("oor.direct.out_valid", valid3, 1'b0);
    mode3 = 2'b01; load3 = 1'b1;
    tick();
    check("oor.load.out", out3, 8'h22);
    check("oor.load.out_valid", valid3, 1'b0);
    sel3 = 2'd2;
    tick();
    check("oor.ok.out", out3, 8'h33);
    check("oor.ok.out_ch", ch3, 2'd2);

    // Randomised traffic with mode runs long enough to cover full scan periods.
    run = 0;
    for (int i = 0; i < 400; i++) begin
      if (run == 0) begin
        mode  = 2'($urandom_range(0, 3));
        mode3 = 2'($urandom_range(0, 3));
        run   = int'($urandom_range(1, 16));
      end
      run--;
      sel   = 2'($urandom);
      load  = 1'($urandom);
      bus   = $urandom;
      sel3  = 2'($urandom);
      load3 = 1'($urandom);
      bus3  = 24'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scan_hold_mux.md
# scan_hold_mux

Parametrised, fully registered N-channel word selector with three operating modes: direct select, explicit hold/load, and timed round-robin scan. It replaces ad-hoc combinational muxes and incompletely specified `if` assignments with a single clocked block, so no latch is ever inferred. Storage is explicit and enabled by `load`. It sits between multi-source data buses and downstream consumers that need a stable, registered word plus the index of the channel it came from.

## Interface
- `WIDTH`, 8: data word width in bits, ≥1.
- `NCH`, 4: number of input channels, ≥2.
- `DWELL`, 4: cycles spent on each channel in scan mode, ≥1.
- `SELW` (localparam): `$clog2(NCH)`, the channel index width.

Ports (one clock; reset is asynchronous and active-low):
- `clock`: in, 1. Rising-edge clock.
- `reset_n`: in, 1. Asynchronous active-low reset.
- `in_bus`: in, NCH*WIDTH. Channel k occupies bits [k*WIDTH +: WIDTH].
- `mode`: in, 2. 00 direct, 01 hold, 10 scan, 11 reserved (behaves as hold).
- `sel`: in, SELW. Channel index for the direct and hold modes.
- `load`: in, 1. Capture strobe in hold mode; ignored in the other modes.
- `out`: out, WIDTH. Registered selected word.
- `out_ch`: out, SELW. Channel index of the word currently in `out`.
- `out_valid`: out, 1. High for the cycle after `out` was written.

## Operation
- **Write condition.** `out`, `out_ch` and `out_valid` are registers. A write stores `in_bus[ch]` into `out` and `ch` into `out_ch`, and sets `out_valid`=1. A cycle without a write keeps `out` and `out_ch` and sets `out_valid`=0.
- **Direct mode (00).** Write `ch=sel` every cycle.
- **Hold mode (01/11).** Write `ch=sel` only when `load`=1. Otherwise `out` holds indefinitely. This is the explicit, clocked replacement for an inferred latch.
- **Scan mode (10).**
  - Internal `scan_ch` (SELW bits) and `dwell_cnt` (`$clog2(DWELL)`, min 1 bit).
  - A write of `ch=scan_ch` occurs every cycle.
  - `dwell_cnt` increments each cycle. When it reaches DWELL-1 it returns to 0 and `scan_ch` advances. The advance wraps from NCH-1 to 0.
- **Entering scan.** A cycle where `mode`=10 and the previous registered mode was not 10 loads `scan_ch`=0 and `dwell_cnt`=0. Channel 0 is written that cycle.
- **Out-of-range select.** If `sel` ≥ NCH in direct mode, or in hold mode with `load`=1, no write occurs and `out_valid`=0. This only applies when NCH is not a power of two.
- **Mode change mid-dwell.** Leaving scan freezes `scan_ch` and `dwell_cnt`. Their values are discarded on the next entry to scan.
- **Input sampling.** `in_bus`, `mode`, `sel` and `load` are sampled only at the rising edge of `clock`. No output is combinationally dependent on any input.

## Timing
- **Reset.** `reset_n` low asynchronously forces:
  - `out`=0, `out_ch`=0, `out_valid`=0;
  - `scan_ch`=0, `dwell_cnt`=0;
  - previous-mode register = 01 (hold).
- **Reset release.** Operation resumes at the first rising edge after `reset_n` goes high.
- **Latency.** Inputs sampled at edge t appear on `out`, `out_ch` and `out_valid` after edge t. Latency is 1 cycle in all modes.
- **Scan cadence.** Each channel occupies exactly DWELL consecutive cycles of `out_ch`. A full scan period is NCH*DWELL cycles.
- **DWELL=1.** The channel advances every cycle.
- **Reset mid-scan.** Reset aborts the scan immediately. After release, if `mode`=10, the first edge is treated as a scan entry and starts at channel 0.

## Configuration
- **`SCAN_HOLD_MUX_SCAN_EN` defined.** Scan mode and its counters are compiled in, as described above.
- **`SCAN_HOLD_MUX_SCAN_EN` undefined.**
  - No scan counters exist.
  - `mode`=10 behaves as hold (01).
  - `DWELL` is ignored.
  - All other behaviour is identical.

## Test plan
- **Reset, then direct select.** Assert reset with WIDTH=8 and NCH=4, then release. Expect `out`=0x00, `out_ch`=0 and `out_valid`=0. Set mode=00, sel=2, in_bus ch2=0xA5. One edge later expect `out`=0xA5, `out_ch`=2, `out_valid`=1.
- **Hold and load.** Set mode=01, load=0, then change ch2 to 0x3C. `out` stays 0xA5 and `out_valid`=0 for 10 cycles. Pulse load=1 with sel=1 and ch1=0x77. Next cycle expect `out`=0x77, `out_ch`=1, `out_valid`=1. The cycle after, expect `out_valid`=0.
- **Scan with wrap.** Set DWELL=3, then switch mode 01→10. `out_ch` must read 0,0,0,1,1,1,2,2,2,3,3,3,0, and `out` must track the matching channel word every cycle.
- **Scan re-entry.** While in scan at ch2, cycle 1 of its dwell, switch to mode 00 for 2 cycles, then back to 10. Expect `out_ch`=0 on the first re-entry cycle.
- **Reset mid-scan and macro off.** Drop `reset_n` mid-scan, asynchronously and between edges. Outputs must zero before the next edge. Then rebuild without `SCAN_HOLD_MUX_SCAN_EN`: with mode=10 and load=0, `out` must hold its value.
- **Out-of-range select.** With NCH=3, set mode=00 and sel=3. `out` and `out_ch` hold, and `out_valid`=0.
